// File: rtl/mips_cpu_harvard_hi_lo_unit.sv
// HI/LO owner for the Harvard MIPS core: iterative MULT/MULTU/DIV/DIVU (32 steps)
// plus single-cycle MTHI/MTLO. Signed ops iterate on magnitudes and fix signs in FINISH.
module mips_cpu_harvard_hi_lo_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [63:0] acc;       // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [31:0] opnd;      // multiplicand or divisor magnitude
  logic [31:0] a_raw;
  logic        is_div, neg_q, neg_r, div0;

  logic        accept, md_op, sgn;
  logic [31:0] abs_a, abs_b;

  assign accept = start && !busy;
  assign md_op  = ~op[2];
  assign sgn    = ~op[0];
  assign abs_a  = (sgn && op_a[31]) ? -op_a : op_a;
  assign abs_b  = (sgn && op_b[31]) ? -op_b : op_b;

  logic [32:0] mul_sum, div_sh;
  logic [31:0] div_diff;
  logic [63:0] acc_step;

  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + {1'b0, opnd};
    div_sh   = acc[63:31];
    div_diff = div_sh[31:0] - opnd;
    acc_step = acc;
    if (is_div) begin
      if (div_sh >= {1'b0, opnd}) acc_step = {div_diff, acc[30:0], 1'b1};
      else                        acc_step = {div_sh[31:0], acc[30:0], 1'b0};
    end else if (acc[0]) begin
      acc_step = {mul_sum, acc[31:1]};
    end else begin
      acc_step = {1'b0, acc[63:1]};
    end
  end

  logic [63:0] res;

  always_comb begin
    res = acc;
    if (!is_div) begin
      if (neg_q) res = -acc;
    end else if (div0) begin
      res = {a_raw, 32'hFFFF_FFFF};
    end else begin
      res[31:0]  = neg_q ? -acc[31:0]  : acc[31:0];
      res[63:32] = neg_r ? -acc[63:32] : acc[63:32];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && md_op) state_nxt = RUN;
      RUN:     if (cnt == 5'd31)    state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          case (op)
            3'b100: hi <= op_a;
            3'b101: lo <= op_a;
            3'b000, 3'b001, 3'b010, 3'b011: begin
              busy   <= 1'b1;
              cnt    <= '0;
              is_div <= op[1];
              acc    <= {32'd0, op[1] ? abs_a : abs_b};
              opnd   <= op[1] ? abs_b : abs_a;
              a_raw  <= op_a;
              neg_q  <= sgn && (op_a[31] ^ op_b[31]);
              neg_r  <= sgn && op_a[31];
              div0   <= (op_b == 32'd0);
            end
            default: ;
          endcase
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + 5'd1;
        end
        FINISH: begin
          {hi, lo} <= res;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_harvard_hi_lo_unit.sv
// Randomized bench for the HI/LO unit against a 64-bit arithmetic reference model.
module tb_mips_cpu_harvard_hi_lo_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int nvec = 0, nerr = 0;
  logic [31:0] ref_hi = '0, ref_lo = '0;

  mips_cpu_harvard_hi_lo_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {HI, LO} as the architecture defines them
  function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (o)
      3'd0: res = sa * sb;
      3'd1: res = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Caller is at a negedge; returns at the negedge after the result is visible.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int spam);
    logic [63:0] exp;
    start = 1'b1; op = o; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); op_a = $urandom; op_b = $urandom;
    if (o <= 3'd3) begin
      exp = ref_md(o, a, b);
      for (int i = 0; i < 33; i++) begin
        chk("busy_run", 64'(busy), 64'd1);
        chk("done_run", 64'(done), 64'd0);
        chk("hilo_hold", {hi, lo}, {ref_hi, ref_lo});
        if (spam == 1) begin
          start = (i == 3) || (i == 10);
          op    = (i == 3) ? 3'd5 : 3'd1;
          op_a  = (i == 3) ? 32'hDEAD : 32'd9;
          op_b  = 32'd9;
        end else begin
          start = (spam == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
          op = 3'($urandom); op_a = $urandom; op_b = $urandom;
        end
        @(negedge clk);
      end
      start = 1'b0;
      {ref_hi, ref_lo} = exp;
      chk("busy_end", 64'(busy), 64'd0);
      chk("done_pulse", 64'(done), 64'd1);
      chk("hilo_result", {hi, lo}, {ref_hi, ref_lo});
    end else begin
      if (o == 3'd4) ref_hi = a;
      if (o == 3'd5) ref_lo = a;
      chk("busy_mt", 64'(busy), 64'd0);
      chk("done_mt", 64'(done), 64'd0);
      chk("hilo_mt", {hi, lo}, {ref_hi, ref_lo});
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 0);
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd3, 32'h1234, 32'd0, 0);
    chk("divu_zero", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(3'd4, 32'hA5A5_A5A5, 32'd0, 0);
    chk("mthi", 64'(hi), 64'hA5A5_A5A5);
    run_op(3'd1, 32'd7, 32'd6, 1);
    chk("mul7x6_ignore", {hi, lo}, 64'd42);

    // reset aborts an in-flight DIVU
    start = 1'b1; op = 3'd3; op_a = 32'hFFFF_0000; op_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    ref_hi = '0; ref_lo = '0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("abort_no_done", 64'(done), 64'd0);
      chk("abort_idle", 64'(busy), 64'd0);
    end
    run_op(3'd5, 32'd1, 32'd0, 0);
    chk("mtlo_after_rst", 64'(lo), 64'd1);

    for (int n = 0; n < 40; n++)
      run_op(3'($urandom), pick(), pick(), ($urandom_range(0, 3) == 0) ? 2 : 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
